// File: rtl/interval_meter_if.sv
// Measurement port of the interval meter: event/abort in, strobed result out.
interface interval_meter_if #(
  parameter int W = 8
);
  logic         evt;
  logic         stop;
  logic [W-1:0] value;
  logic         get;
  logic         over;
  logic         armed;

  modport master (
    output evt,
    output stop,
    input  value,
    input  get,
    input  over,
    input  armed
  );

  modport slave (
    input  evt,
    input  stop,
    output value,
    output get,
    output over,
    output armed
  );
endinterface

// File: rtl/interval_meter_edge_detect.sv
// Rising-edge detector for an already-synchronous input.
// The delay register resets high so an input held high through reset is not taken as an edge.
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic din_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) din_q <= 1'b1;
    else        din_q <= din;
  end

  assign rise = din & ~din_q;
endmodule

// File: rtl/interval_meter.sv
// Counts clock cycles between successive rising edges of evt and strobes each result.
//   state | meaning
//   IDLE  | waiting for a rising edge to start timing
//   RUN   | timing an interval; each edge closes one interval and opens the next
module interval_meter #(
  parameter int W = 8
) (
  input  logic             clock,
  input  logic             reset,
  interval_meter_if.slave  bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};

  state_t       state;
  logic [W-1:0] cnt;
  logic [W-1:0] value_r;
  logic         get_r;
  logic         over_r;
  logic         armed_r;
  logic         edge_hit;

  edge_detect u_edge (
    .clock (clock),
    .reset (reset),
    .din   (bus.evt),
    .rise  (edge_hit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      value_r <= '0;
      get_r   <= 1'b0;
      over_r  <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      get_r <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.stop && edge_hit) begin
            cnt     <= '0;
            state   <= RUN;
            armed_r <= 1'b1;
          end
        end
        RUN: begin
          // stop outranks a coinciding edge or timeout
          if (bus.stop) begin
            state   <= IDLE;
            armed_r <= 1'b0;
          end else if (edge_hit) begin
            value_r <= cnt + 1'b1;
            over_r  <= 1'b0;
            get_r   <= 1'b1;
            cnt     <= '0;
          end else if (cnt == CNT_LAST) begin
            value_r <= CNT_MAX;
            over_r  <= 1'b1;
            get_r   <= 1'b1;
            state   <= IDLE;
            armed_r <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          armed_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.value = value_r;
  assign bus.get   = get_r;
  assign bus.over  = over_r;
  assign bus.armed = armed_r;
endmodule

// File: doc/interval_meter.md
Name: interval_meter

Overview:
- Inverse of the timer family (alarm/timeout/pulse/strobe), which turn a loaded count into an event. This block turns events into a count.
- Measures the number of clock cycles between successive rising edges of a synchronous event input.
- Presents each measurement with a one-cycle strobe, the same value/strobe pairing the timers consume.
- Used to characterise timer outputs in-system, and as a general period/interval meter.

Parameters:
- W, 8, width of counter and measured value; largest reportable interval MAX = 2^W-1 cycles.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- event  in  1  input under measurement; already synchronous to clock. Only rising edges are significant.
- stop   in  1  synchronous abort: return to IDLE and discard the interval in progress.
- value  out W  last measured interval in cycles; held between strobes.
- get    out 1  one-cycle strobe; value and over are valid in the same cycle.
- over   out 1  qualifies get: 1 = interval reached MAX with no closing edge (timeout).
- armed  out 1  1 while in state RUN (an interval is being timed).

Behaviour:
- Reset (asynchronous, reset=0) sets:
  - state=IDLE, cnt=0, value=0, get=0, over=0, armed=0.
  - event_q=1, so an input already high at reset release does not arm the block.
- Edge detection: edge = event & ~event_q, evaluated each clock; event_q <= event every clock.
- States and transitions:
  - IDLE:
    - stop=1: stay in IDLE.
    - else on edge: cnt <= 0, go to RUN, armed <= 1.
    - get stays 0.
  - RUN, checked in priority order:
    1. stop=1: go to IDLE, armed <= 0, no strobe. Applies even if edge or timeout coincide.
    2. edge: value <= cnt+1, over <= 0, get <= 1, cnt <= 0, stay in RUN. Back-to-back periods are measured with no gap.
    3. cnt == MAX-1 and no edge: value <= MAX, over <= 1, get <= 1, go to IDLE, armed <= 0.
    4. otherwise: cnt <= cnt+1.
- Timing and arithmetic:
  - Rising edges sampled at clock edges k0 and k1 give value = k1-k0. get is high in the cycle after the clock edge that samples the closing edge (latency 1).
  - Minimum measurable interval is 2, because event must be low for at least one sample between edges.
  - An interval of exactly MAX cycles ends in the edge branch: value=MAX, over=0. Timeout only fires when no edge arrives at that cycle.
  - cnt never exceeds MAX-1 and never wraps.
- get is deasserted in every cycle that does not take the edge or timeout branch.
- value and over hold until the next strobe. stop and the timeout do not clear value.
- After a timeout the block is in IDLE. The next rising edge re-arms it but produces no strobe.
- A reset asserted mid-interval returns every output to its reset value immediately. No strobe is issued.

Decomposition:
- No package is needed. State encoding (IDLE, RUN) is local parameters in the module.
- Natural sub-module: edge_detect (event_q register plus rising-edge output, reset value 1). It is small and reusable by the other timer blocks.
- The counter and FSM stay in interval_meter.

Test Plan:
- Reset behaviour: hold reset=0 with event=1, then release → no edge detected; armed=0, get=0, value=0 until event falls and rises again.
- Steady period, W=8: rising edges every 17 cycles (0x11), four of them → the first edge arms the block only (no strobe). Three strobes follow, each with value=0x11, over=0, armed=1 throughout.
- Back-to-back and minimum period: period 7, then immediately period 2 → strobes with value=0x07, then 0x02. No missing strobe, no extra strobe.
- Boundary at MAX, W=8: closing edge exactly 255 cycles after arming → value=0xFF, over=0, block stays armed. Re-arm and send no edge → 255 cycles after arming: get=1, value=0xFF, over=1, armed=0. A later edge re-arms with no strobe.
- Abort: stop=1 asserted in the same cycle as the closing edge → no get, armed=0, value keeps its previous measurement.
- Asynchronous reset mid-interval: pulse reset low between clock edges while armed → value, get, over, armed go to 0 immediately, without waiting for a clock edge.
